instruction_decoder: RTL and testbench

- Instruction decoder of the TTM4 4-bit emulator core.
- Takes the 15-bit instruction word read from program memory, split as OP[4:0], LR[2:0], SR[2:0] and IM[3:0], plus the ALU Z/C flags.
- Produces registered, active-low bus-enable, store-strobe and ALU-enable controls for the register file and ALU, and the PC-load and stack controls.
- Sits between the memory block and the registers block.

---
 rtl/ttm4_pkg.sv | 92 +++++++++
 rtl/instruction_decoder.sv | 99 +++++++++
 tb/tb_instruction_decoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ttm4_pkg.sv
// Shared encodings for the TTM4 emulator core: opcodes, register codes, STOREBUS selects,
// and the combinational decode used by the instruction decoder.
package ttm4_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_MOV  = 5'b00001;
  localparam logic [4:0] OP_JMP  = 5'b01100;
  localparam logic [4:0] OP_JZ   = 5'b01101;
  localparam logic [4:0] OP_JC   = 5'b01110;
  localparam logic [4:0] OP_ADD  = 5'b10100;
  localparam logic [4:0] OP_AND  = 5'b10101;
  localparam logic [4:0] OP_OR   = 5'b10110;
  localparam logic [4:0] OP_XOR  = 5'b10111;
  localparam logic [4:0] OP_PUSH = 5'b11000;
  localparam logic [4:0] OP_POP  = 5'b11001;

  // LR/SR codes; 100/101 are IRD/IRU as a source and ORD/ORU as a destination.
  localparam logic [2:0] REG_IM   = 3'b000;
  localparam logic [2:0] REG_NONE = 3'b001;
  localparam logic [2:0] REG_A    = 3'b010;
  localparam logic [2:0] REG_B    = 3'b011;
  localparam logic [2:0] REG_XRD  = 3'b100;
  localparam logic [2:0] REG_XRU  = 3'b101;
  localparam logic [2:0] REG_JRU  = 3'b110;
  localparam logic [2:0] REG_JRD  = 3'b111;

  typedef enum logic [1:0] {
    SEL_IM    = 2'b00,
    SEL_ALU   = 2'b01,
    SEL_STACK = 2'b10,
    SEL_RSVD  = 2'b11
  } sel_e;

  // Active-high decode result; bit i of src/dst addresses register code i+2.
  typedef struct packed {
    logic [5:0] src;
    logic [5:0] dst;
    sel_e       sel;
    logic [3:0] alu;      // [0] FA, [1] AND, [2] OR, [3] XOR
    logic       stack;
    logic       sp_upd;
    logic       sp_down;
    logic       pc_ld;
    logic       spc;
  } ctrl_t;

  function automatic logic [5:0] reg_onehot(input logic [2:0] code);
    logic [7:0] full;
    full = 8'b1 << code;
    return full[7:2];
  endfunction

  function automatic ctrl_t decode_op(input logic [4:0] op, input logic [2:0] lr,
                                      input logic [2:0] sr, input logic z, input logic c);
    ctrl_t d;
    d     = '0;
    d.sel = SEL_IM;
    case (op)
      OP_MOV: begin
        d.src = reg_onehot(sr);
        d.dst = reg_onehot(lr);
      end
      OP_ADD, OP_AND, OP_OR, OP_XOR: begin
        d.src = reg_onehot(sr);
        d.dst = reg_onehot(lr);
        d.sel = SEL_ALU;
        d.alu = 4'b0001 << op[1:0];
      end
      OP_JMP: d.pc_ld = 1'b1;
      OP_JZ:  d.pc_ld = z;
      OP_JC:  d.pc_ld = c;
      OP_PUSH: begin
        d.src     = reg_onehot(sr);
        d.stack   = 1'b1;
        d.sp_upd  = 1'b1;
        d.sp_down = 1'b0;
        d.spc     = 1'b1;
      end
      OP_POP: begin
        d.dst     = reg_onehot(lr);
        d.stack   = 1'b1;
        d.sp_upd  = 1'b1;
        d.sp_down = 1'b1;
        d.spc     = 1'b1;
        d.sel     = SEL_STACK;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// TTM4 instruction decoder: registers the decoded OP/LR/SR/flags into active-low
// bus, store, ALU and stack controls one cycle after sampling.
module instruction_decoder
  import ttm4_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       Z_FLAG,
  input  logic       C_FLAG,
  input  logic [2:0] LR,
  input  logic [2:0] SR,
  input  logic [4:0] OP,
  output logic       nA_OUT,
  output logic       nB_OUT,
  output logic       nIRU_OUT,
  output logic       nIRD_OUT,
  output logic       nJRU_OUT,
  output logic       nJRD_OUT,
  output logic       nA_ST,
  output logic       nB_ST,
  output logic       nORU_ST,
  output logic       nORD_ST,
  output logic       nJRU_ST,
  output logic       nJRD_ST,
  output logic [1:0] SEL,
  output logic       nFA_EN,
  output logic       nAND_EN,
  output logic       nOR_EN,
  output logic       nXOR_EN,
  output logic       nSK_EN,
  output logic       SP_D_nU,
  output logic       PC_nLD,
  output logic       SPC
);

  ctrl_t      dec;
  logic [5:0] n_out_q;
  logic [5:0] n_st_q;
  logic [3:0] n_alu_q;
  sel_e       sel_q;
  logic       n_sk_q;
  logic       sp_dir_q;
  logic       pc_nld_q;
  logic       spc_q;

  assign dec = decode_op(OP, LR, SR, Z_FLAG, C_FLAG);

  // NOTE: reset is sampled on the clock edge only, so it lives inside the
  // clocked branch rather than in the sensitivity list.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      n_out_q  <= '1;
      n_st_q   <= '1;
      n_alu_q  <= '1;
      sel_q    <= SEL_IM;
      n_sk_q   <= 1'b1;
      sp_dir_q <= 1'b0;
      pc_nld_q <= 1'b1;
      spc_q    <= 1'b0;
    end else begin
      n_out_q  <= ~dec.src;
      n_st_q   <= ~dec.dst;
      n_alu_q  <= ~dec.alu;
      sel_q    <= dec.sel;
      n_sk_q   <= ~dec.stack;
      pc_nld_q <= ~dec.pc_ld;
      spc_q    <= dec.spc;
      // Direction holds its last stack operation while idle.
      if (dec.sp_upd) sp_dir_q <= dec.sp_down;
    end
  end

  assign nA_OUT   = n_out_q[0];
  assign nB_OUT   = n_out_q[1];
  assign nIRD_OUT = n_out_q[2];
  assign nIRU_OUT = n_out_q[3];
  assign nJRU_OUT = n_out_q[4];
  assign nJRD_OUT = n_out_q[5];

  assign nA_ST    = n_st_q[0];
  assign nB_ST    = n_st_q[1];
  assign nORD_ST  = n_st_q[2];
  assign nORU_ST  = n_st_q[3];
  assign nJRU_ST  = n_st_q[4];
  assign nJRD_ST  = n_st_q[5];

  assign nFA_EN   = n_alu_q[0];
  assign nAND_EN  = n_alu_q[1];
  assign nOR_EN   = n_alu_q[2];
  assign nXOR_EN  = n_alu_q[3];

  assign SEL      = sel_q;
  assign nSK_EN   = n_sk_q;
  assign SP_D_nU  = sp_dir_q;
  assign PC_nLD   = pc_nld_q;
  assign SPC      = spc_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed vector table, reset
// sequences, and randomized instructions against a behavioural model.
module tb_instruction_decoder;
  import ttm4_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Z_FLAG = 1'b0, C_FLAG = 1'b0;
  logic [2:0] LR = '0, SR = '0;
  logic [4:0] OP = '0;
  logic nA_OUT, nB_OUT, nIRU_OUT, nIRD_OUT, nJRU_OUT, nJRD_OUT;
  logic nA_ST, nB_ST, nORU_ST, nORD_ST, nJRU_ST, nJRD_ST;
  logic [1:0] SEL;
  logic nFA_EN, nAND_EN, nOR_EN, nXOR_EN, nSK_EN, SP_D_nU, PC_nLD, SPC;

  instruction_decoder dut (
    .CLK(CLK), .RST(RST), .Z_FLAG(Z_FLAG), .C_FLAG(C_FLAG), .LR(LR), .SR(SR), .OP(OP),
    .nA_OUT(nA_OUT), .nB_OUT(nB_OUT), .nIRU_OUT(nIRU_OUT), .nIRD_OUT(nIRD_OUT),
    .nJRU_OUT(nJRU_OUT), .nJRD_OUT(nJRD_OUT),
    .nA_ST(nA_ST), .nB_ST(nB_ST), .nORU_ST(nORU_ST), .nORD_ST(nORD_ST),
    .nJRU_ST(nJRU_ST), .nJRD_ST(nJRD_ST), .SEL(SEL),
    .nFA_EN(nFA_EN), .nAND_EN(nAND_EN), .nOR_EN(nOR_EN), .nXOR_EN(nXOR_EN),
    .nSK_EN(nSK_EN), .SP_D_nU(SP_D_nU), .PC_nLD(PC_nLD), .SPC(SPC)
  );

  always #10 CLK = ~CLK;

  // Raw pin values, active-low fields kept active-low.
  typedef struct packed {
    logic a_out, b_out, iru_out, ird_out, jru_out, jrd_out;
    logic a_st, b_st, oru_st, ord_st, jru_st, jrd_st;
    logic [1:0] sel;
    logic fa_en, and_en, or_en, xor_en;
    logic sk, sp_d_nu, pc_nld, spc;
  } out_t;

  typedef struct {
    logic [4:0] op;
    logic [2:0] lr, sr;
    logic       z, c;
    out_t       exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic model_sp = 1'b0;

  function automatic out_t idle_o(input logic sp);
    out_t o;
    o = '1;
    o.sel = 2'b00;
    o.sp_d_nu = sp;
    o.spc = 1'b0;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{a_out:nA_OUT, b_out:nB_OUT, iru_out:nIRU_OUT, ird_out:nIRD_OUT,
          jru_out:nJRU_OUT, jrd_out:nJRD_OUT, a_st:nA_ST, b_st:nB_ST,
          oru_st:nORU_ST, ord_st:nORD_ST, jru_st:nJRU_ST, jrd_st:nJRD_ST,
          sel:SEL, fa_en:nFA_EN, and_en:nAND_EN, or_en:nOR_EN, xor_en:nXOR_EN,
          sk:nSK_EN, sp_d_nu:SP_D_nU, pc_nld:PC_nLD, spc:SPC};
    return o;
  endfunction

  function automatic vec_t mk(input logic [4:0] op, input logic [2:0] lr, input logic [2:0] sr,
                              input logic z, input logic c, input out_t e);
    vec_t v;
    v.op = op; v.lr = lr; v.sr = sr; v.z = z; v.c = c; v.exp = e;
    return v;
  endfunction

  // Behavioural reference: which register reads, which writes, which unit drives STOREBUS.
  function automatic out_t model(input logic [4:0] op, input logic [2:0] lr, input logic [2:0] sr,
                                 input logic z, input logic c, input logic sp);
    out_t o;
    bit alu, rd, wr;
    o   = idle_o(sp);
    alu = (op == OP_ADD) || (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
    rd  = (op == OP_MOV) || alu || (op == OP_PUSH);
    wr  = (op == OP_MOV) || alu || (op == OP_POP);
    if (rd) begin
      if (sr == 3'd2) o.a_out = 1'b0;
      if (sr == 3'd3) o.b_out = 1'b0;
      if (sr == 3'd4) o.ird_out = 1'b0;
      if (sr == 3'd5) o.iru_out = 1'b0;
      if (sr == 3'd6) o.jru_out = 1'b0;
      if (sr == 3'd7) o.jrd_out = 1'b0;
    end
    if (wr) begin
      if (lr == 3'd2) o.a_st = 1'b0;
      if (lr == 3'd3) o.b_st = 1'b0;
      if (lr == 3'd4) o.ord_st = 1'b0;
      if (lr == 3'd5) o.oru_st = 1'b0;
      if (lr == 3'd6) o.jru_st = 1'b0;
      if (lr == 3'd7) o.jrd_st = 1'b0;
    end
    if (alu) o.sel = 2'b01;
    if (op == OP_ADD) o.fa_en  = 1'b0;
    if (op == OP_AND) o.and_en = 1'b0;
    if (op == OP_OR)  o.or_en  = 1'b0;
    if (op == OP_XOR) o.xor_en = 1'b0;
    if (op == OP_JMP || (op == OP_JZ && z) || (op == OP_JC && c)) o.pc_nld = 1'b0;
    if (op == OP_PUSH) begin o.sk = 1'b0; o.sp_d_nu = 1'b0; o.spc = 1'b1; end
    if (op == OP_POP)  begin o.sk = 1'b0; o.sp_d_nu = 1'b1; o.spc = 1'b1; o.sel = 2'b10; end
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  task automatic step(input logic [4:0] op, input logic [2:0] lr, input logic [2:0] sr,
                      input logic z, input logic c, input logic rst);
    @(negedge CLK);
    OP = op; LR = lr; SR = sr; Z_FLAG = z; C_FLAG = c; RST = rst;
    @(posedge CLK);
    #1;
  endtask

  vec_t v[16];
  out_t e;

  initial begin
    // Directed sequence starting right after reset (stack direction 0).
    e = idle_o(0); e.a_st = 0;                                     v[0]  = mk(OP_MOV, 3'b010, 3'b000, 0, 0, e);
    e = idle_o(0); e.a_out = 0; e.fa_en = 0; e.a_st = 0; e.sel = 2'b01; v[1] = mk(OP_ADD, 3'b010, 3'b010, 0, 0, e);
    e = idle_o(0); e.jrd_st = 0;                                   v[2]  = mk(OP_MOV, 3'b111, 3'b000, 0, 0, e);
    e = idle_o(0); e.pc_nld = 0;                                   v[3]  = mk(OP_JMP, 3'b000, 3'b000, 0, 0, e);
    e = idle_o(0);                                                 v[4]  = mk(OP_JZ,  3'b000, 3'b000, 0, 1, e);
    e = idle_o(0); e.pc_nld = 0;                                   v[5]  = mk(OP_JZ,  3'b000, 3'b000, 1, 0, e);
    e = idle_o(0);                                                 v[6]  = mk(OP_JC,  3'b000, 3'b000, 1, 0, e);
    e = idle_o(0); e.pc_nld = 0;                                   v[7]  = mk(OP_JC,  3'b000, 3'b000, 0, 1, e);
    e = idle_o(0); e.b_out = 0; e.sk = 0; e.spc = 1;               v[8]  = mk(OP_PUSH, 3'b000, 3'b011, 0, 0, e);
    e = idle_o(1); e.sk = 0; e.spc = 1; e.sel = 2'b10; e.a_st = 0; v[9]  = mk(OP_POP, 3'b010, 3'b000, 0, 0, e);
    e = idle_o(1);                                                 v[10] = mk(5'b11111, 3'b010, 3'b010, 1, 1, e);
    e = idle_o(1); e.ird_out = 0; e.and_en = 0; e.oru_st = 0; e.sel = 2'b01; v[11] = mk(OP_AND, 3'b101, 3'b100, 0, 0, e);
    e = idle_o(1); e.jrd_out = 0; e.or_en = 0; e.b_st = 0; e.sel = 2'b01;    v[12] = mk(OP_OR, 3'b011, 3'b111, 0, 0, e);
    e = idle_o(1); e.xor_en = 0; e.sel = 2'b01;                    v[13] = mk(OP_XOR, 3'b000, 3'b001, 0, 0, e);
    e = idle_o(1); e.iru_out = 0; e.jru_st = 0;                    v[14] = mk(OP_MOV, 3'b110, 3'b101, 0, 0, e);
    e = idle_o(1);                                                 v[15] = mk(OP_NOP, 3'b010, 3'b010, 1, 1, e);

    for (int i = 0; i < 4; i++) begin
      step(5'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      check($sformatf("reset%0d", i), sample(), idle_o(0));
    end

    for (int i = 0; i < 16; i++) begin
      step(v[i].op, v[i].lr, v[i].sr, v[i].z, v[i].c, 1'b0);
      check($sformatf("vec%0d", i), sample(), v[i].exp);
    end

    // Mid-program reset overrides a live ALU op and clears the stack direction.
    step(OP_ADD, 3'b010, 3'b010, 0, 0, 1'b1);
    check("mid_reset", sample(), idle_o(0));
    step(OP_NOP, 3'b000, 3'b000, 0, 0, 1'b0);
    check("post_reset_nop", sample(), idle_o(0));

    model_sp = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      logic [2:0] lr, sr;
      logic z, c, rst;
      out_t exp;
      logic [4:0] ops [11] = '{OP_NOP, OP_MOV, OP_ADD, OP_AND, OP_OR, OP_XOR,
                               OP_JMP, OP_JZ, OP_JC, OP_PUSH, OP_POP};
      op  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : ops[$urandom_range(0, 10)];
      lr  = 3'($urandom); sr = 3'($urandom);
      z   = 1'($urandom); c  = 1'($urandom);
      rst = ($urandom_range(0, 19) == 0);
      exp = rst ? idle_o(0) : model(op, lr, sr, z, c, model_sp);
      step(op, lr, sr, z, c, rst);
      check($sformatf("rand%0d op=%05b lr=%03b sr=%03b z=%0b c=%0b rst=%0b", i, op, lr, sr, z, c, rst),
            sample(), exp);
      model_sp = exp.sp_d_nu;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
